// File: rtl/pattern_detector.sv
// pattern_detector
//   Serial bit-pattern detector. It shifts in one qualified bit per clock and
//   raises a registered one-cycle pulse on `out` each time the last WIDTH
//   accepted bits equal PATTERN (MSB = first bit received). Overlapping or
//   non-overlapping matching is selected at run time. It also keeps a
//   saturating match counter and has a synchronous clear.
//
// Parameters
//   WIDTH    pattern length in bits (2..16)
//   PATTERN  target pattern, MSB received first
//   CNT_W    match counter width (2..16)
//
// Ports
//   clock        in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   in           in   serial data bit
//   x            in   bit-valid qualifier
//   overlap      in   1 = overlapping matches, 0 = history dropped after a match
//   clear        in   synchronous clear of history, fill and counter
//   out          out  registered one-cycle match pulse
//   match_count  out  saturating match count since reset/clear
//   saturated    out  high while match_count is all ones
//
// Qualifier semantics: `in` is consumed on a rising edge only when x=1. There
// is no back-pressure, so the block accepts every qualified bit. When x=0 the
// bit is ignored and all history holds.
module pattern_detector #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
   parameter int               CNT_W   = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in,
   input  logic             x,
   input  logic             overlap,
   input  logic             clear,
   output logic             out,
   output logic [CNT_W-1:0] match_count,
   output logic             saturated
);

   localparam int                FILL_W    = $clog2(WIDTH + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic [WIDTH-1:0]  hist,  hist_d,  hist_shift;
   logic [FILL_W-1:0] fill,  fill_d,  fill_inc;
   logic [CNT_W-1:0]  count_d;
   logic              out_d;
   logic              match;

   // Next-state logic
   always_comb begin
      hist_shift = {hist[WIDTH-2:0], in};
      fill_inc   = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
      // fill gates the compare. Until WIDTH bits have been accepted since
      // reset/clear/non-overlap match, the zero-initialised history cannot
      // produce a false hit (for example with an all-zero PATTERN).
      match      = (fill_inc == FILL_FULL) && (hist_shift == PATTERN);

      hist_d  = hist;
      fill_d  = fill;
      count_d = match_count;
      out_d   = 1'b0;

      if (x) begin
         hist_d = hist_shift;
         fill_d = fill_inc;
         out_d  = match;
         if (match) begin
            if (match_count != CNT_MAX) begin
               count_d = match_count + 1'b1;
            end
            // Non-overlap: the next match needs WIDTH fresh bits.
            if (!overlap) begin
               fill_d = '0;
            end
         end
      end
   end

   // State registers. Reset and clear have the same effect. The bit presented
   // with clear is dropped.
   always_ff @(posedge clock) begin
      if (!reset_n || clear) begin
         hist        <= '0;
         fill        <= '0;
         match_count <= '0;
         out         <= 1'b0;
      end else begin
         hist        <= hist_d;
         fill        <= fill_d;
         match_count <= count_d;
         out         <= out_d;
      end
   end

   assign saturated = (match_count == CNT_MAX);

endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector. It instantiates three copies:
//   a: WIDTH=4 PATTERN=1011 CNT_W=8 (main)
//   b: WIDTH=4 PATTERN=1011 CNT_W=2 (saturation)
//   c: WIDTH=2 PATTERN=00   CNT_W=4 (all-zero pattern / fill gating)
// All three copies receive the same inputs. A queue-based reference model
// keeps the accepted bits since the last reset/clear/non-overlap match.
module tb_pattern_detector;

   logic clock = 1'b0;
   logic reset_n, in, x, overlap, clear;
   logic       out_a, sat_a, out_b, sat_b, out_c, sat_c;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;
   logic [3:0] cnt_c;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   // reference model state
   logic qa[$];
   logic qc[$];
   logic [3:0] pat_a = 4'b1011;
   logic [1:0] pat_c = 2'b00;
   logic       mo_a, mo_c;
   int         ca, cb, cc;

   always #5 clock = ~clock;

   pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
      .clock(clock), .reset_n(reset_n), .in(in), .x(x), .overlap(overlap),
      .clear(clear), .out(out_a), .match_count(cnt_a), .saturated(sat_a));

   pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
      .clock(clock), .reset_n(reset_n), .in(in), .x(x), .overlap(overlap),
      .clear(clear), .out(out_b), .match_count(cnt_b), .saturated(sat_b));

   pattern_detector #(.WIDTH(2), .PATTERN(2'b00), .CNT_W(4)) dut_c (
      .clock(clock), .reset_n(reset_n), .in(in), .x(x), .overlap(overlap),
      .clear(clear), .out(out_c), .match_count(cnt_c), .saturated(sat_c));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive on the falling edge, update the model at the rising edge,
   // and compare 1 time unit later.
   task automatic cycle(input logic b, input logic xv, input logic ov,
                        input logic clr, input logic rst);
      logic m;
      @(negedge clock);
      in = b; x = xv; overlap = ov; clear = clr; reset_n = rst;
      @(posedge clock);
      mo_a = 1'b0;
      mo_c = 1'b0;
      if (!rst || clr) begin
         qa.delete(); qc.delete();
         ca = 0; cb = 0; cc = 0;
      end else if (xv) begin
         qa.push_back(b);
         if (qa.size() > 4) void'(qa.pop_front());
         if (qa.size() == 4) begin
            m = 1'b1;
            for (int i = 0; i < 4; i++) if (qa[i] !== pat_a[3-i]) m = 1'b0;
            if (m) begin
               mo_a = 1'b1;
               if (ca < 255) ca++;
               if (cb < 3) cb++;
               if (!ov) qa.delete();
            end
         end
         qc.push_back(b);
         if (qc.size() > 2) void'(qc.pop_front());
         if (qc.size() == 2) begin
            m = 1'b1;
            for (int i = 0; i < 2; i++) if (qc[i] !== pat_c[1-i]) m = 1'b0;
            if (m) begin
               mo_c = 1'b1;
               if (cc < 15) cc++;
               if (!ov) qc.delete();
            end
         end
      end
      #1;
      chk("out_a", 32'(out_a), 32'(mo_a));
      chk("cnt_a", 32'(cnt_a), 32'(ca));
      chk("sat_a", 32'(sat_a), 32'(ca == 255));
      chk("out_b", 32'(out_b), 32'(mo_a));
      chk("cnt_b", 32'(cnt_b), 32'(cb));
      chk("sat_b", 32'(sat_b), 32'(cb == 3));
      chk("out_c", 32'(out_c), 32'(mo_c));
      chk("cnt_c", 32'(cnt_c), 32'(cc));
      chk("sat_c", 32'(sat_c), 32'(cc == 15));
      if (out_b) pulses++;
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n, input logic ov);
      for (int i = 0; i < n; i++) cycle(bits[n-1-i], 1'b1, ov, 1'b0, 1'b1);
   endtask

   typedef struct {
      logic       b, xv, ov, clr;
      logic       exp_out;
      logic [7:0] exp_cnt;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic b, input logic xv, input logic ov, input logic clr,
                      input logic eo, input logic [7:0] ec);
      vec_t v;
      v.b = b; v.xv = xv; v.ov = ov; v.clr = clr; v.exp_out = eo; v.exp_cnt = ec;
      tbl.push_back(v);
   endtask

   initial begin
      in = 0; x = 0; overlap = 0; clear = 0; reset_n = 0;

      // reset state
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_out", 32'(out_a), 32'd0);
      chk("rst_cnt", 32'(cnt_a), 32'd0);
      chk("rst_sat", 32'(sat_b), 32'd0);

      // overlap=1 stream 1011011
      add(1,1,1,0, 0,0); add(0,1,1,0, 0,0); add(1,1,1,0, 0,0); add(1,1,1,0, 1,1);
      add(0,1,1,0, 0,1); add(1,1,1,0, 0,1); add(1,1,1,0, 1,2);
      add(0,0,0,1, 0,0);
      // overlap=0, same stream
      add(1,1,0,0, 0,0); add(0,1,0,0, 0,0); add(1,1,0,0, 0,0); add(1,1,0,0, 1,1);
      add(0,1,0,0, 0,1); add(1,1,0,0, 0,1); add(1,1,0,0, 0,1);
      add(0,0,0,1, 0,0);
      // 1011 with x=0 gap cycles, in toggling in the gaps
      add(1,1,1,0, 0,0); add(0,0,1,0, 0,0); add(0,1,1,0, 0,0); add(1,0,1,0, 0,0);
      add(1,1,1,0, 0,0); add(0,0,1,0, 0,0); add(1,1,1,0, 1,1); add(1,0,1,0, 0,1);
      foreach (tbl[i]) begin
         cycle(tbl[i].b, tbl[i].xv, tbl[i].ov, tbl[i].clr, 1'b1);
         chk($sformatf("tbl_out[%0d]", i), 32'(out_a), 32'(tbl[i].exp_out));
         chk($sformatf("tbl_cnt[%0d]", i), 32'(cnt_a), 32'(tbl[i].exp_cnt));
      end

      // saturation with CNT_W=2: five overlapping matches
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      pulses = 0;
      send_bits(16'b1011_0110_1101_1011, 16, 1'b1);
      chk("sat_pulses", 32'(pulses), 32'd5);
      chk("sat_cnt_a", 32'(cnt_a), 32'd5);
      chk("sat_cnt_b", 32'(cnt_b), 32'd3);
      chk("sat_flag_b", 32'(sat_b), 32'd1);

      // clear on the final bit of 1011, then 011 gives nothing
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      send_bits(16'b101, 3, 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("clr_out", 32'(out_a), 32'd0);
      chk("clr_cnt", 32'(cnt_a), 32'd0);
      pulses = 0;
      send_bits(16'b011, 3, 1'b1);
      chk("clr_nopulse", 32'(pulses), 32'd0);

      // reset mid-pattern
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      send_bits(16'b101, 3, 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      pulses = 0;
      send_bits(16'b1, 1, 1'b1);
      chk("rstmid_nopulse", 32'(pulses), 32'd0);
      send_bits(16'b1011, 4, 1'b1);
      chk("rstmid_pulse", 32'(pulses), 32'd1);
      chk("rstmid_cnt", 32'(cnt_a), 32'd1);

      // all-zero pattern: first bit after clear must not match
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("zero_first", 32'(out_c), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("zero_second", 32'(out_c), 32'd1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("zero_nonovl", 32'(out_c), 32'd0);

      // randomized stimulus against the model
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 49) == 0),
               1'($urandom_range(0, 79) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Parametrised serial bit-pattern detector, the successor to the single-pattern `source` FSM. It shifts in one qualified bit per clock and pulses `out` on each occurrence of a configurable `WIDTH`-bit pattern. Overlap and non-overlap matching are selectable at run time. A saturating match counter and a synchronous clear are included. It sits directly behind the serial input stage and is driven cycle-by-cycle by the file-driven bench (`in`/`x` vectors, `out` logged per clock).

## Interface
- `WIDTH`, 4: pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1011: target pattern; MSB = first bit received.
- `CNT_W`, 8: match counter width; legal range 2..16.

- `clock`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low; clock clock.
- `in`  in  1  serial data bit.
- `x`  in  1  bit-valid qualifier; `in` is sampled only when `x`=1.
- `overlap`  in  1  1 = overlapping matches allowed; 0 = history discarded after a match.
- `clear`  in  1  synchronous clear of history, fill and counter.
- `out`  out  1  registered one-cycle match pulse.
- `match_count`  out  CNT_W  saturating count of matches since reset/clear.
- `saturated`  out  1  high while `match_count` = 2^CNT_W−1.

## Operation
- State: `hist[WIDTH-1:0]` (last accepted bits), `fill` (0..WIDTH, number of valid bits in `hist`), `match_count`, `out`.
- Priority per edge: `reset_n`=0 > `clear`=1 > `x`=1 > idle.
- Reset (`reset_n`=0): `hist`=0, `fill`=0, `match_count`=0, `out`=0, `saturated`=0.
- `clear`=1: same as reset. The bit presented that cycle is discarded, even if `x`=1.
- `x`=1 (accept):
  - hist_n = {hist[WIDTH-2:0], in}; fill_n = min(fill+1, WIDTH).
  - match = (fill_n == WIDTH) && (hist_n == PATTERN).
  - `out` <= match.
  - On match: `match_count` <= `match_count`+1 unless already at max, where it holds.
  - On match with `overlap`=0: `fill` <= 0, so the next match needs WIDTH fresh bits.
  - On match with `overlap`=1: `fill` stays WIDTH.
  - `hist` <= hist_n in all cases.
- `x`=0: `hist`, `fill` and `match_count` hold; `out` <= 0.
- `overlap` is sampled on the accept edge. Changing it mid-stream affects only matches completed on or after that edge.
- `saturated` is combinational from `match_count` (all ones).
- Bits received before `fill` reaches WIDTH can never match, even if `hist` (zero-initialised) happens to equal `PATTERN`. This includes an all-zero PATTERN.

## Timing
- Latency: `out` goes high in the cycle immediately after the rising edge that accepts the final pattern bit. The pulse is exactly 1 cycle per match.
- `match_count` updates on the same edge that sets `out`.
- Back-to-back matches (overlap=1 with a periodic pattern, e.g. 11 on a stream of 1s) give `out` high on consecutive cycles. This is not a level hold; each cycle is a separate match.
- First possible `out` pulse: WIDTH accepted bits after reset/clear.
- Reset or clear asserted mid-pattern: no pulse for the partial pattern. Counting restarts from fill=0 on the next edge.
- No combinational path from any input to `out` or `match_count`.

## Test plan
- WIDTH=4, PATTERN=1011, overlap=1, x=1, stream 1,0,1,1,0,1,1 -> `out` pulses in the cycles after bits 4 and 7; `match_count`=2.
- Same stream with overlap=0 -> single pulse after bit 4; `match_count`=1.
- Stream 1,0,1,1 with x=0 cycles interleaved (in toggling while x=0) -> exactly one pulse, one cycle after the 4th qualified bit; `out`=0 on all gap cycles.
- CNT_W=2, overlap=1, stream 1011011011011011 (5 matches) -> `match_count` goes 1,2,3,3,3; `saturated`=1 from the 3rd match; `out` still pulses 5 times.
- `clear`=1 on the edge presenting the final '1' of 1011 with x=1 -> `out`=0 and `match_count`=0. Sending 0,1,1 next gives no pulse, because `fill` is only 3.
- `reset_n`=0 for one cycle after 1,0,1, then 1 -> no pulse; a following full 1011 gives a pulse and `match_count`=1.
